// File: rtl/joy_db15_pkg.sv
// rtl/joy_db15_pkg.sv - shared constants, FSM encoding and button layout for the DB15 joystick link
// Contents: frame/word widths, transmitter state encoding, LS FEDCBAUDLR bit indices,
//           frame assembly helper (pressed buttons become low bits on the wire).
package joy_db15_pkg;

  localparam int FRAME_BITS = 32;
  localparam int WORD_BITS  = 16;

  // Legacy-compatible state constants; the enum below names the same encodings.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_LOAD    = 2'd1;
  localparam logic [1:0] ST_SHIFT   = 2'd2;
  localparam logic [1:0] ST_DRAINED = 2'd3;

  typedef enum logic [1:0] {
    TX_IDLE    = ST_IDLE,
    TX_LOAD    = ST_LOAD,
    TX_SHIFT   = ST_SHIFT,
    TX_DRAINED = ST_DRAINED
  } db15_tx_state_t;

  // Button word layout, LSB first: R L D U A B C D E F, then S and L above them.
  localparam int BTN_RIGHT = 0;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_UP    = 3;
  localparam int BTN_A     = 4;
  localparam int BTN_B     = 5;
  localparam int BTN_C     = 6;
  localparam int BTN_D     = 7;
  localparam int BTN_E     = 8;
  localparam int BTN_F     = 9;
  localparam int BTN_S     = 10;
  localparam int BTN_L     = 11;

  // Player 1 occupies frame bits 0..15, player 2 bits 16..31; the wire is active-low.
  function automatic logic [FRAME_BITS-1:0] frame_of(input logic [WORD_BITS-1:0] joy1,
                                                     input logic [WORD_BITS-1:0] joy2);
    return {~joy2, ~joy1};
  endfunction

endpackage

// File: rtl/joy_db15_tx_sync_filt.sv
// rtl/joy_db15_tx_sync_filt.sv - strobe synchronizer, stability filter and edge pulses
// Ports: clk, reset (async, active-high), din (asynchronous strobe),
//        rise/fall (one-cycle pulses on the cycle the filtered level changes).
module joy_sync_filt #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT        = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise,
  output logic fall
);

  localparam int CW = (FILT > 1) ? $clog2(FILT) : 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_q;
  logic [CW-1:0]          cnt_q;
  logic                   sync_out;
  logic                   accept;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // The sample that completes a run of FILT differing samples is accepted on the same
  // edge, so the pulse lines up with the filtered level update.
  assign accept = (sync_out != level_q) && (cnt_q == CW'(FILT - 1));
  assign rise   = accept &  sync_out;
  assign fall   = accept & ~sync_out;

  // Everything resets high so an idle-high strobe produces no event at reset release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '1;
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      if (sync_out == level_q) begin
        cnt_q <= '0;
      end else if (accept) begin
        level_q <= sync_out;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/joy_db15_tx.sv
// rtl/joy_db15_tx.sv - device-side DB15 joystick shift-chain responder
// Ports: clk (system clock), reset (async, active-high), joy_clk/joy_load (host strobes),
//        joystick1/joystick2 (active-high buttons), joy_data (serial out, active-low),
//        bit_count (bits shifted since load, 0..32), frame_done (pulse after bit 31).
module joy_db15_tx
  import joy_db15_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT        = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 joy_clk,
  input  logic                 joy_load,
  input  logic [WORD_BITS-1:0] joystick1,
  input  logic [WORD_BITS-1:0] joystick2,
  output logic                 joy_data,
  output logic [5:0]           bit_count,
  output logic                 frame_done
);

  logic                  clk_rise;
  logic                  clk_fall;
  logic                  load_rise;
  logic                  load_fall;
  logic [1:0]            state;
  logic [FRAME_BITS-1:0] shift_q;
  logic [FRAME_BITS-1:0] live_frame;

  joy_sync_filt #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT        (FILT)
  ) u_clk_filt (
    .clk   (clk),
    .reset (reset),
    .din   (joy_clk),
    .rise  (clk_rise),
    .fall  (clk_fall)
  );

  joy_sync_filt #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT        (FILT)
  ) u_load_filt (
    .clk   (clk),
    .reset (reset),
    .din   (joy_load),
    .rise  (load_rise),
    .fall  (load_fall)
  );

  // Falling shift-clock edges never act on the chain.
  logic unused_clk_fall;
  assign unused_clk_fall = clk_fall;

  assign live_frame = frame_of(joystick1, joystick2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      shift_q    <= '1;
      joy_data   <= 1'b1;
      bit_count  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      // A load fall takes priority over any shift edge accepted in the same cycle and
      // abandons a partial frame without signalling completion.
      if (load_fall) begin
        state     <= ST_LOAD;
        shift_q   <= live_frame;
        joy_data  <= live_frame[0];
        bit_count <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            joy_data  <= 1'b1;
            bit_count <= '0;
          end
          ST_LOAD: begin
            // Transparent while load is low, like a '165 in parallel-load mode.
            shift_q   <= live_frame;
            joy_data  <= live_frame[0];
            bit_count <= '0;
            if (load_rise) begin
              state <= ST_SHIFT;
            end
          end
          ST_SHIFT: begin
            if (clk_rise) begin
              // Serial-in is tied high, so the register drains to all ones.
              shift_q   <= {1'b1, shift_q[FRAME_BITS-1:1]};
              joy_data  <= shift_q[1];
              bit_count <= bit_count + 6'd1;
              if (bit_count == 6'(FRAME_BITS - 1)) begin
                frame_done <= 1'b1;
                state      <= ST_DRAINED;
              end
            end
          end
          ST_DRAINED: begin
            joy_data <= 1'b1;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_joy_db15_tx.sv
// tb/tb_joy_db15_tx.sv - table-driven and directed checks for joy_db15_tx
module tb_joy_db15_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        joy_clk = 1'b0;
  logic        joy_load = 1'b1;
  logic [15:0] joystick1 = 16'h0000;
  logic [15:0] joystick2 = 16'h0000;
  logic        joy_data;
  logic [5:0]  bit_count;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  always #10 clk = ~clk;

  joy_db15_tx #(
    .SYNC_STAGES (2),
    .FILT        (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .joy_clk    (joy_clk),
    .joy_load   (joy_load),
    .joystick1  (joystick1),
    .joystick2  (joystick2),
    .joy_data   (joy_data),
    .bit_count  (bit_count),
    .frame_done (frame_done)
  );

  always @(negedge clk) begin
    if (frame_done === 1'b1) done_cnt++;
  end

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_pulse();
    joy_load = 1'b0;
    wait_cyc(8);
    joy_load = 1'b1;
    wait_cyc(8);
  endtask

  task automatic clk_pulse();
    joy_clk = 1'b1;
    wait_cyc(6);
    joy_clk = 1'b0;
    wait_cyc(6);
  endtask

  typedef struct {
    logic [15:0] j1;
    logic [15:0] j2;
    logic [31:0] frame;
    int          nclk;
    int          exp_count;
    int          exp_done;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int          base;
    logic [31:0] f;
    logic        exp_bit;

    tbl[0] = '{16'h0001, 16'h8000, 32'h7FFF_FFFE, 32, 32, 1};
    tbl[1] = '{16'h0000, 16'h0000, 32'hFFFF_FFFF, 40, 32, 1};
    tbl[2] = '{16'hA5C3, 16'h0F0F, 32'hF0F0_5A3C, 32, 32, 1};
    tbl[3] = '{16'hFFFF, 16'hFFFF, 32'h0000_0000, 33, 32, 1};
    tbl[4] = '{16'h1234, 16'hABCD, 32'h5432_EDCB, 10, 10, 0};

    wait_cyc(3);
    check("reset_joy_data", {31'd0, joy_data}, 32'd1);
    check("reset_bit_count", {26'd0, bit_count}, 32'd0);
    check("reset_frame_done", {31'd0, frame_done}, 32'd0);
    reset = 1'b0;
    wait_cyc(10);
    check("idle_joy_data", {31'd0, joy_data}, 32'd1);
    check("idle_done", done_cnt, 0);

    // Table-driven frames; button inputs are scrambled after load to prove the snapshot holds.
    for (int r = 0; r < 5; r++) begin
      f = tbl[r].frame;
      joystick1 = tbl[r].j1;
      joystick2 = tbl[r].j2;
      load_pulse();
      joystick1 = ~tbl[r].j1;
      joystick2 = tbl[r].j2 ^ 16'h5A5A;
      base = done_cnt;
      check($sformatf("row%0d_load_bit0", r), {31'd0, joy_data}, {31'd0, f[0]});
      check($sformatf("row%0d_load_count", r), {26'd0, bit_count}, 32'd0);
      for (int i = 1; i <= tbl[r].nclk; i++) begin
        clk_pulse();
        exp_bit = (i < 32) ? f[i] : 1'b1;
        check($sformatf("row%0d_bit%0d_data", r, i), {31'd0, joy_data}, {31'd0, exp_bit});
        check($sformatf("row%0d_bit%0d_count", r, i), {26'd0, bit_count},
              (i < 32) ? i : 32);
        check($sformatf("row%0d_bit%0d_done", r, i), done_cnt - base, (i >= 32) ? 1 : 0);
      end
      check($sformatf("row%0d_final_count", r), {26'd0, bit_count}, tbl[r].exp_count);
      check($sformatf("row%0d_final_done", r), done_cnt - base, tbl[r].exp_done);
    end

    // Mid-frame reload: the row-4 frame is still in flight at bit 10.
    base = done_cnt;
    joystick1 = 16'h0001;
    joystick2 = 16'h0000;
    joy_load = 1'b0;
    wait_cyc(8);
    check("reload_count", {26'd0, bit_count}, 32'd0);
    check("reload_bit0", {31'd0, joy_data}, 32'd0);
    joy_load = 1'b1;
    wait_cyc(8);
    check("reload_no_done", done_cnt - base, 0);

    // Glitch rejection: frame bit0=1, bit1=0.
    joystick1 = 16'h0002;
    load_pulse();
    check("glitch_pre_data", {31'd0, joy_data}, 32'd1);
    joy_clk = 1'b1;
    wait_cyc(1);
    joy_clk = 1'b0;
    wait_cyc(10);
    check("glitch_count", {26'd0, bit_count}, 32'd0);
    check("glitch_data", {31'd0, joy_data}, 32'd1);
    joy_clk = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pulse4_after3_data", {31'd0, joy_data}, 32'd1);
    check("pulse4_after3_count", {26'd0, bit_count}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("pulse4_after4_data", {31'd0, joy_data}, 32'd0);
    check("pulse4_after4_count", {26'd0, bit_count}, 32'd1);
    joy_clk = 1'b0;
    wait_cyc(10);
    check("pulse4_fall_count", {26'd0, bit_count}, 32'd1);

    // Load and clock edge accepted together: load wins.
    joy_clk = 1'b1;
    joy_load = 1'b0;
    wait_cyc(8);
    check("simul_count", {26'd0, bit_count}, 32'd0);
    check("simul_bit0", {31'd0, joy_data}, 32'd1);
    joy_clk = 1'b0;
    wait_cyc(8);

    // Transparent load (still low from above).
    joystick1 = 16'h0001;
    @(posedge clk);
    @(negedge clk);
    check("transp_press", {31'd0, joy_data}, 32'd0);
    joystick1 = 16'h0000;
    @(posedge clk);
    @(negedge clk);
    check("transp_release", {31'd0, joy_data}, 32'd1);
    joystick1 = 16'h0001;
    wait_cyc(2);
    joy_load = 1'b1;
    wait_cyc(8);
    joystick1 = 16'h0000;
    wait_cyc(6);
    check("frozen_bit0", {31'd0, joy_data}, 32'd0);
    clk_pulse();
    check("frozen_bit1", {31'd0, joy_data}, 32'd1);

    // Reset mid-shift at bit 17 (frame bit 17 is low).
    joystick1 = 16'h0000;
    joystick2 = 16'h0002;
    load_pulse();
    base = done_cnt;
    repeat (17) clk_pulse();
    check("pre_reset_count", {26'd0, bit_count}, 32'd17);
    check("pre_reset_data", {31'd0, joy_data}, 32'd0);
    reset = 1'b1;
    #1;
    check("async_reset_data", {31'd0, joy_data}, 32'd1);
    check("async_reset_count", {26'd0, bit_count}, 32'd0);
    wait_cyc(2);
    reset = 1'b0;
    wait_cyc(4);
    repeat (3) clk_pulse();
    check("post_reset_count", {26'd0, bit_count}, 32'd0);
    check("post_reset_data", {31'd0, joy_data}, 32'd1);
    check("post_reset_no_done", done_cnt - base, 0);
    joystick1 = 16'h0001;
    load_pulse();
    check("post_reset_load_bit0", {31'd0, joy_data}, 32'd0);
    clk_pulse();
    check("post_reset_shift_count", {26'd0, bit_count}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
